// File: rtl/spill_splitter.sv
// Drain side of the task-spill path: reads a spilled slot back into the task queue,
// then retires the slot in its chunk counter and returns full chunks to the free stack.
module spill_splitter #(
    parameter int unsigned TASKS_PER_SPLITTER      = 8,
    parameter int unsigned LOG_TASK_BYTES          = 4,
    parameter int unsigned LOG_SPLITTERS_PER_CHUNK = 2,
    parameter int unsigned LOG_STACK_ENTRY_BYTES   = 2,
    parameter int unsigned TQ_WIDTH                = 128
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cfg_start,
    input  logic [37:0]         cfg_spill_base,
    input  logic [37:0]         cfg_stack_base,
    input  logic [37:0]         cfg_scratch_base,
    input  logic [37:0]         cfg_stack_ptr_addr,
    input  logic                split_valid,
    output logic                split_ready,
    input  logic [15:0]         split_coal_id,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [TQ_WIDTH-1:0] out_task,
    output logic                stack_lock_out,
    input  logic                stack_lock_in,
    output logic                arvalid,
    input  logic                arready,
    output logic [63:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    input  logic                rvalid,
    output logic                rready,
    input  logic [511:0]        rdata,
    input  logic                rlast,
    output logic                awvalid,
    input  logic                awready,
    output logic [63:0]         awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic                wvalid,
    input  logic                wready,
    output logic [511:0]        wdata,
    output logic [63:0]         wstrb,
    output logic                wlast,
    input  logic                bvalid,
    output logic                bready,
    output logic                busy,
    output logic                err
);

    localparam int unsigned BEAT_W     = (TASKS_PER_SPLITTER > 1) ? $clog2(TASKS_PER_SPLITTER) : 1;
    localparam int unsigned SLOT_SHIFT = LOG_TASK_BYTES + $clog2(TASKS_PER_SPLITTER);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(TASKS_PER_SPLITTER - 1);
    localparam logic [31:0] SLOTS_PER_CHUNK = 32'(1 << LOG_SPLITTERS_PER_CHUNK);

    typedef enum logic [3:0] {
        IDLE, RD_SLOT, STREAM, GRAB_LOCK, CHECK_LOCK, RD_CNT, RD_CNT_WAIT, WR_CNT,
        WR_CNT_WAIT, RD_PTR, RD_PTR_WAIT, WR_ENTRY, WR_ENTRY_WAIT, WR_PTR, WR_PTR_WAIT, RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       coal_q, coal_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [15:0]       ptr_q, ptr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              lock_q, lock_d;
    logic              err_q, err_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;

    logic [15:0] chunk;
    logic [31:0] cnt_inc;
    logic        chunk_full;
    logic [15:0] ptr_dec;
    logic [63:0] slot_addr, cnt_addr, entry_addr, ptr_addr;
    logic        wr_req, wr_fire;
    logic        unused_ok;

    assign chunk      = coal_q >> LOG_SPLITTERS_PER_CHUNK;
    assign cnt_inc    = cnt_q + 32'd1;
    assign chunk_full = (cnt_inc == SLOTS_PER_CHUNK);
    assign ptr_dec    = ptr_q - 16'd1;
    assign slot_addr  = 64'(cfg_spill_base) + (64'(coal_q) << SLOT_SHIFT);
    assign cnt_addr   = 64'(cfg_scratch_base) + (64'(chunk) << 2);
    assign entry_addr = 64'(cfg_stack_base) + (64'(ptr_dec) << LOG_STACK_ENTRY_BYTES);
    assign ptr_addr   = 64'(cfg_stack_ptr_addr);

    assign out_task       = rdata[TQ_WIDTH-1:0];
    assign stack_lock_out = lock_q;
    assign err            = err_q;
    assign busy           = (state_q != IDLE);
    assign unused_ok      = ^{rlast, rdata};

    // aw and w are issued together; either may be accepted first
    assign wr_req  = (state_q == WR_CNT) || (state_q == WR_ENTRY) || (state_q == WR_PTR);
    assign wr_fire = wr_req && (aw_done_q || awready) && (w_done_q || wready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            coal_q    <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            beat_q    <= '0;
            lock_q    <= 1'b0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            coal_q    <= coal_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            beat_q    <= beat_d;
            lock_q    <= lock_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        coal_d      = coal_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        beat_d      = beat_q;
        err_d       = err_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        split_ready = 1'b0;
        out_valid   = 1'b0;
        arvalid     = 1'b0;
        araddr      = '0;
        arlen       = '0;
        arsize      = '0;
        rready      = 1'b0;
        awaddr      = '0;
        awlen       = '0;
        awsize      = '0;
        wdata       = '0;
        bready      = 1'b0;

        case (state_q)
            IDLE: begin
                split_ready = cfg_start;
                if (cfg_start && split_valid) begin
                    coal_d  = split_coal_id;
                    beat_d  = '0;
                    state_d = RD_SLOT;
                end
            end
            RD_SLOT: begin
                arvalid = 1'b1;
                araddr  = slot_addr;
                arlen   = 8'(TASKS_PER_SPLITTER - 1);
                arsize  = 3'(LOG_TASK_BYTES);
                if (arready) state_d = STREAM;
            end
            STREAM: begin
                out_valid = rvalid;
                rready    = out_ready;
                if (rvalid && out_ready) begin
                    if (beat_q == BEAT_LAST) begin
                        beat_d  = '0;
                        state_d = GRAB_LOCK;
                    end else begin
                        beat_d = BEAT_W'(beat_q + 1'b1);
                    end
                end
            end
            GRAB_LOCK: begin
                if (!stack_lock_in) state_d = CHECK_LOCK;
            end
            CHECK_LOCK: state_d = RD_CNT;
            RD_CNT: begin
                arvalid = 1'b1;
                araddr  = cnt_addr;
                arsize  = 3'd2;
                if (arready) state_d = RD_CNT_WAIT;
            end
            RD_CNT_WAIT: begin
                rready = 1'b1;
                if (rvalid) begin
                    cnt_d   = rdata[31:0];
                    state_d = WR_CNT;
                end
            end
            WR_CNT: begin
                awaddr = cnt_addr;
                awsize = 3'd2;
                wdata  = 512'(chunk_full ? 32'd0 : cnt_inc);
                if (wr_fire) state_d = WR_CNT_WAIT;
            end
            WR_CNT_WAIT: begin
                bready = 1'b1;
                if (bvalid) state_d = chunk_full ? RD_PTR : RELEASE;
            end
            RD_PTR: begin
                arvalid = 1'b1;
                araddr  = ptr_addr;
                arsize  = 3'd1;
                if (arready) state_d = RD_PTR_WAIT;
            end
            RD_PTR_WAIT: begin
                rready = 1'b1;
                if (rvalid) begin
                    ptr_d = rdata[15:0];
                    if (rdata[15:0] == 16'd0) begin
                        err_d   = 1'b1;
                        state_d = RELEASE;
                    end else begin
                        state_d = WR_ENTRY;
                    end
                end
            end
            WR_ENTRY: begin
                awaddr = entry_addr;
                awsize = 3'(LOG_STACK_ENTRY_BYTES);
                wdata  = 512'(chunk);
                if (wr_fire) state_d = WR_ENTRY_WAIT;
            end
            WR_ENTRY_WAIT: begin
                bready = 1'b1;
                if (bvalid) state_d = WR_PTR;
            end
            WR_PTR: begin
                awaddr = ptr_addr;
                awsize = 3'd1;
                wdata  = 512'(ptr_dec);
                if (wr_fire) state_d = WR_PTR_WAIT;
            end
            WR_PTR_WAIT: begin
                bready = 1'b1;
                if (bvalid) state_d = RELEASE;
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (wr_req) begin
            aw_done_d = wr_fire ? 1'b0 : (aw_done_q || awready);
            w_done_d  = wr_fire ? 1'b0 : (w_done_q || wready);
        end

        // lock is held from CHECK_LOCK through the last write response; dropped on entering RELEASE
        lock_d = state_d inside {CHECK_LOCK, RD_CNT, RD_CNT_WAIT, WR_CNT, WR_CNT_WAIT, RD_PTR,
                                 RD_PTR_WAIT, WR_ENTRY, WR_ENTRY_WAIT, WR_PTR, WR_PTR_WAIT};
    end

    assign awvalid = wr_req && !aw_done_q;
    assign wvalid  = wr_req && !w_done_q;
    assign wlast   = wvalid;
    assign wstrb   = wvalid ? '1 : '0;

endmodule

// File: tb/tb_spill_splitter.sv
// Directed bench for spill_splitter: plays the AXI slave and coalescer lock by hand.
module tb_spill_splitter;

    logic         clk = 1'b0;
    logic         rstn;
    logic         cfg_start;
    logic [37:0]  cfg_spill_base, cfg_stack_base, cfg_scratch_base, cfg_stack_ptr_addr;
    logic         split_valid, split_ready;
    logic [15:0]  split_coal_id;
    logic         out_valid, out_ready;
    logic [127:0] out_task;
    logic         stack_lock_out, stack_lock_in;
    logic         arvalid, arready;
    logic [63:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic         rvalid, rready, rlast;
    logic [511:0] rdata;
    logic         awvalid, awready;
    logic [63:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic         wvalid, wready, wlast;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         bvalid, bready;
    logic         busy, err;

    int n_checks = 0;
    int n_errors = 0;
    int ar_hs = 0;
    int aw_hs = 0;

    spill_splitter dut (
        .clk(clk), .rstn(rstn), .cfg_start(cfg_start),
        .cfg_spill_base(cfg_spill_base), .cfg_stack_base(cfg_stack_base),
        .cfg_scratch_base(cfg_scratch_base), .cfg_stack_ptr_addr(cfg_stack_ptr_addr),
        .split_valid(split_valid), .split_ready(split_ready), .split_coal_id(split_coal_id),
        .out_valid(out_valid), .out_ready(out_ready), .out_task(out_task),
        .stack_lock_out(stack_lock_out), .stack_lock_in(stack_lock_in),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (arvalid && arready) ar_hs++;
        if (awvalid && awready) aw_hs++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [127:0] beat_val(input logic [15:0] coal, input int k);
        return 128'({16'hA5A5, coal, 8'(k)});
    endfunction

    task automatic serve_ar(input string tag, input logic [63:0] a, input logic [7:0] l,
                            input logic [2:0] s, input int stall);
        int n = 0;
        while (!arvalid && n < 50) begin step(); n++; end
        check({tag, "_arvalid"}, 128'(arvalid), 128'(1));
        check({tag, "_araddr"}, 128'(araddr), 128'(a));
        check({tag, "_arlen"}, 128'(arlen), 128'(l));
        check({tag, "_arsize"}, 128'(arsize), 128'(s));
        for (int i = 0; i < stall; i++) begin
            step();
            check({tag, "_arhold"}, 128'(arvalid), 128'(1));
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
    endtask

    task automatic serve_rd1(input string tag, input logic [31:0] d);
        int n = 0;
        rdata = '1;
        rdata[31:0] = d;
        rvalid = 1'b1;
        rlast = 1'b1;
        #1;
        while (!rready && n < 50) begin step(); n++; end
        check({tag, "_rready"}, 128'(rready), 128'(1));
        step();
        rvalid = 1'b0;
        rlast = 1'b0;
    endtask

    task automatic serve_wr(input string tag, input logic [63:0] a, input logic [2:0] s,
                            input logic [31:0] d);
        int n = 0;
        while (!awvalid && n < 50) begin step(); n++; end
        check({tag, "_awvalid"}, 128'(awvalid), 128'(1));
        check({tag, "_wvalid"}, 128'(wvalid), 128'(1));
        check({tag, "_awaddr"}, 128'(awaddr), 128'(a));
        check({tag, "_awsize"}, 128'(awsize), 128'(s));
        check({tag, "_awlen"}, 128'(awlen), 128'(0));
        check({tag, "_wlast"}, 128'(wlast), 128'(1));
        check({tag, "_wstrb"}, 128'(wstrb), 128'(64'hFFFF_FFFF_FFFF_FFFF));
        check({tag, "_wdata"}, wdata[127:0], 128'(d));
        check({tag, "_bready_early"}, 128'(bready), 128'(0));
        awready = 1'b1;
        wready = 1'b1;
        step();
        awready = 1'b0;
        wready = 1'b0;
        check({tag, "_awdone"}, 128'(awvalid), 128'(0));
        bvalid = 1'b1;
        #1;
        check({tag, "_bready"}, 128'(bready), 128'(1));
        step();
        bvalid = 1'b0;
    endtask

    // Streams 8 beats with out_ready following pat[cycle % 4]
    task automatic stream(input string tag, input logic [15:0] coal, input logic [3:0] pat);
        int k = 0;
        int cyc = 0;
        while (k < 8 && cyc < 100) begin
            rdata = '1;
            rdata[127:0] = beat_val(coal, k);
            rvalid = 1'b1;
            rlast = (k == 7);
            out_ready = pat[cyc % 4];
            #1;
            check({tag, "_ovalid"}, 128'(out_valid), 128'(1));
            check({tag, "_rready"}, 128'(rready), 128'(out_ready));
            check({tag, "_otask"}, out_task, beat_val(coal, k));
            step();
            if (out_ready) k++;
            cyc++;
        end
        check({tag, "_beats"}, 128'(k), 128'(8));
        rdata[127:0] = beat_val(coal, 8);
        out_ready = 1'b1;
        #1;
        check({tag, "_extra_rready"}, 128'(rready), 128'(0));
        check({tag, "_extra_ovalid"}, 128'(out_valid), 128'(0));
        rvalid = 1'b0;
        rlast = 1'b0;
    endtask

    task automatic do_task(input int id, input logic [15:0] coal, input logic [3:0] pat,
                           input int lock_busy, input bit same_grab,
                           input logic [63:0] slot_addr, input logic [63:0] cnt_addr,
                           input logic [31:0] cnt_rd, input logic [31:0] cnt_wr,
                           input bit complete, input logic [15:0] ptr_rd,
                           input logic [63:0] entry_addr, input logic [31:0] entry_data,
                           input logic [15:0] ptr_wr);
        string t = $sformatf("t%0d", id);
        int ar0 = ar_hs;
        int aw0 = aw_hs;
        int exp_ar = complete ? 3 : 2;
        int exp_aw = (complete && ptr_rd != 16'd0) ? 3 : 1;
        bit exp_err = complete && (ptr_rd == 16'd0);

        split_coal_id = coal;
        split_valid = 1'b1;
        #1;
        check({t, "_sready"}, 128'(split_ready), 128'(1));
        step();
        split_valid = 1'b0;
        check({t, "_busy"}, 128'(busy), 128'(1));
        serve_ar({t, "_slot"}, slot_addr, 8'd7, 3'd4, 2);
        stream({t, "_st"}, coal, pat);
        check({t, "_lock_grab"}, 128'(stack_lock_out), 128'(0));
        if (lock_busy > 0) begin
            stack_lock_in = 1'b1;
            for (int i = 0; i < lock_busy; i++) begin
                step();
                check({t, "_lock_wait"}, 128'(stack_lock_out), 128'(0));
                check({t, "_ar_wait"}, 128'(arvalid), 128'(0));
            end
            stack_lock_in = 1'b0;
        end
        step();
        check({t, "_lock_on"}, 128'(stack_lock_out), 128'(1));
        check({t, "_ar_chk"}, 128'(arvalid), 128'(0));
        if (same_grab) stack_lock_in = 1'b1;
        step();
        check({t, "_cnt_ar_now"}, 128'(arvalid), 128'(1));
        serve_ar({t, "_cnt"}, cnt_addr, 8'd0, 3'd2, 0);
        serve_rd1({t, "_cnt"}, cnt_rd);
        serve_wr({t, "_cntw"}, cnt_addr, 3'd2, cnt_wr);
        if (complete) begin
            check({t, "_lock_ptr"}, 128'(stack_lock_out), 128'(1));
            serve_ar({t, "_ptr"}, 64'h4000, 8'd0, 3'd1, 0);
            serve_rd1({t, "_ptr"}, 32'(ptr_rd));
            if (ptr_rd != 16'd0) begin
                serve_wr({t, "_entry"}, entry_addr, 3'd2, entry_data);
                serve_wr({t, "_ptrw"}, 64'h4000, 3'd1, 32'(ptr_wr));
            end
        end
        check({t, "_rel_lock"}, 128'(stack_lock_out), 128'(0));
        check({t, "_rel_busy"}, 128'(busy), 128'(1));
        check({t, "_err"}, 128'(err), 128'(exp_err));
        step();
        check({t, "_idle"}, 128'(busy), 128'(0));
        check({t, "_ar_total"}, 128'(ar_hs - ar0), 128'(exp_ar));
        check({t, "_aw_total"}, 128'(aw_hs - aw0), 128'(exp_aw));
        stack_lock_in = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        cfg_start = 1'b0;
        cfg_spill_base = 38'h1000;
        cfg_scratch_base = 38'h2000;
        cfg_stack_base = 38'h3000;
        cfg_stack_ptr_addr = 38'h4000;
        split_valid = 1'b0;
        split_coal_id = '0;
        out_ready = 1'b0;
        stack_lock_in = 1'b0;
        arready = 1'b0;
        rvalid = 1'b0;
        rdata = '0;
        rlast = 1'b0;
        awready = 1'b0;
        wready = 1'b0;
        bvalid = 1'b0;
        step();
        step();
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_lock", 128'(stack_lock_out), 128'(0));
        check("rst_arvalid", 128'(arvalid), 128'(0));
        check("rst_awvalid", 128'(awvalid), 128'(0));
        check("rst_wvalid", 128'(wvalid), 128'(0));
        check("rst_bready", 128'(bready), 128'(0));
        check("rst_rready", 128'(rready), 128'(0));
        check("rst_ovalid", 128'(out_valid), 128'(0));
        check("rst_sready", 128'(split_ready), 128'(0));
        rstn = 1'b1;
        step();

        split_valid = 1'b1;
        split_coal_id = 16'd6;
        #1;
        check("nostart_sready", 128'(split_ready), 128'(0));
        step();
        check("nostart_busy", 128'(busy), 128'(0));
        split_valid = 1'b0;
        cfg_start = 1'b1;

        do_task(1, 16'd6, 4'b1111, 0, 1'b0, 64'h1300, 64'h2004, 32'd1, 32'd2, 1'b0, 16'd0, 64'h0, 32'd0, 16'd0);
        do_task(2, 16'd5, 4'b1111, 0, 1'b0, 64'h1280, 64'h2004, 32'd3, 32'd0, 1'b1, 16'd10, 64'h3024, 32'd1, 16'd9);
        do_task(3, 16'd9, 4'b1001, 0, 1'b0, 64'h1480, 64'h2008, 32'd0, 32'd1, 1'b0, 16'd0, 64'h0, 32'd0, 16'd0);
        do_task(4, 16'd0, 4'b1111, 5, 1'b0, 64'h1000, 64'h2000, 32'd2, 32'd3, 1'b0, 16'd0, 64'h0, 32'd0, 16'd0);
        do_task(5, 16'd1, 4'b1111, 0, 1'b1, 64'h1080, 64'h2000, 32'd0, 32'd1, 1'b0, 16'd0, 64'h0, 32'd0, 16'd0);
        do_task(6, 16'd7, 4'b1111, 0, 1'b0, 64'h1380, 64'h2004, 32'd3, 32'd0, 1'b1, 16'd0, 64'h0, 32'd0, 16'd0);
        check("t6_err_sticky", 128'(err), 128'(1));

        // reset pulsed mid-stream
        split_coal_id = 16'd2;
        split_valid = 1'b1;
        step();
        split_valid = 1'b0;
        serve_ar("t7_slot", 64'h1100, 8'd7, 3'd4, 0);
        rdata = '0;
        rvalid = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        step();
        check("t7_mid_ovalid", 128'(out_valid), 128'(1));
        rstn = 1'b0;
        #1;
        check("t7_rst_ovalid", 128'(out_valid), 128'(0));
        check("t7_rst_rready", 128'(rready), 128'(0));
        check("t7_rst_busy", 128'(busy), 128'(0));
        check("t7_rst_err", 128'(err), 128'(0));
        check("t7_rst_lock", 128'(stack_lock_out), 128'(0));
        rvalid = 1'b0;
        step();
        rstn = 1'b1;
        step();

        do_task(8, 16'd3, 4'b1111, 0, 1'b0, 64'h1180, 64'h2000, 32'd1, 32'd2, 1'b0, 16'd0, 64'h0, 32'd0, 16'd0);
        cfg_spill_base = 38'h3F_FFFF_F000;
        do_task(9, 16'hFFFF, 4'b0110, 0, 1'b0, 64'h40_007F_EF80, 64'h1_1FFC, 32'd5, 32'd6, 1'b0, 16'd0, 64'h0, 32'd0, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spill_splitter.md
Name: spill_splitter

Overview:
- Drain side of the task-spill path: consumes SPLITTER-type tasks, each carrying a spill slot id (coal_id).
- For each task: burst-reads that slot's TASKS_PER_SPLITTER spilled tasks from memory and re-emits them to the tile task queue.
- Tracks slot retirement per chunk in a scratchpad counter; when every slot of a chunk is consumed, pushes the chunk id back onto the shared free-chunk stack under the stack lock.
- Lock is shared with the spill-side coalescer; this block has lock priority.

Parameters:
- TASKS_PER_SPLITTER, 8, tasks per slot (burst length).
- LOG_TASK_BYTES, 4, log2 bytes per task beat (TQ_WIDTH ≤ 8·2^LOG_TASK_BYTES).
- LOG_SPLITTERS_PER_CHUNK, 2, log2 slots per chunk.
- LOG_STACK_ENTRY_BYTES, 2, log2 bytes per stack entry.
- TQ_WIDTH, 128, task width in bits.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- cfg_start  in  1  enable; 0 accepts no new task
- cfg_spill_base, cfg_stack_base, cfg_scratch_base, cfg_stack_ptr_addr  in  38 each  byte addresses
- split_valid/split_ready  in/out  1  input splitter task handshake
- split_coal_id  in  16  slot id
- out_valid/out_ready  out/in  1  re-emitted task handshake
- out_task  out  TQ_WIDTH  task = rdata[TQ_WIDTH-1:0]
- stack_lock_out  out  1  lock request/hold
- stack_lock_in  in  1  coalescer lock
- arvalid/arready, araddr[63:0], arlen[7:0], arsize[2:0]  AXI read address (arid=0)
- rvalid/rready, rdata[511:0], rlast  AXI read data
- awvalid/awready, awaddr[63:0], awlen[7:0], awsize[2:0]  AXI write address (awid=0)
- wvalid/wready, wdata[511:0], wstrb[63:0], wlast  AXI write data
- bvalid/bready  AXI write response
- busy  out  1  FSM not IDLE
- err  out  1  sticky: stack-pointer underflow

Behaviour:
- Reset (async, rstn=0): FSM→IDLE; all valid/ready/lock outputs, busy and err are 0; latched id, counter and pointer are 0. Reset mid-burst or mid-lock drops everything; stack_lock_out falls in the same cycle as rstn.
- Exactly one outstanding AXI transaction. bready=1 only in *_WAIT write states. aw and w are presented in the same cycle, single beat, wlast=1, wstrb=all ones.
- IDLE: split_ready=cfg_start. On handshake, latch coal_id, compute chunk=coal_id>>LOG_SPLITTERS_PER_CHUNK, then go to RD_SLOT.
- RD_SLOT: arvalid=1; araddr=cfg_spill_base+(coal_id<<(LOG_TASK_BYTES+log2 TASKS_PER_SPLITTER)); arlen=TASKS_PER_SPLITTER-1; arsize=LOG_TASK_BYTES. On arready go to STREAM.
- STREAM: out_valid=rvalid; rready=out_ready (combinational pass-through, zero added latency, no data loss under backpressure). Count beats. Accepted beat with count=TASKS_PER_SPLITTER-1 (rlast expected) goes to GRAB_LOCK.
- GRAB_LOCK: if !stack_lock_in, register stack_lock_out=1 and go to CHECK_LOCK; else stay.
- CHECK_LOCK: keep lock (priority over the coalescer on a same-cycle grab); go to RD_CNT.
- RD_CNT/RD_CNT_WAIT: 4-byte read at cfg_scratch_base+(chunk<<2); latch cnt=rdata[31:0].
- WR_CNT/WR_CNT_WAIT: write (cnt+1==2^LOG_SPLITTERS_PER_CHUNK) ? 0 : cnt+1 to the same address. After bvalid: if the chunk is complete go to RD_PTR, else go to RELEASE.
- RD_PTR/RD_PTR_WAIT: 2-byte read at cfg_stack_ptr_addr; latch ptr=rdata[15:0]. If ptr==0, set err and go to RELEASE with no stack write.
- WR_ENTRY/WR_ENTRY_WAIT: write chunk to cfg_stack_base+((ptr-1)<<LOG_STACK_ENTRY_BYTES), awsize=LOG_STACK_ENTRY_BYTES.
- WR_PTR/WR_PTR_WAIT: write ptr-1 to cfg_stack_ptr_addr. The entry write precedes the pointer write.
- RELEASE: stack_lock_out←0; go to IDLE.
- cfg_start falling mid-operation does not abort; the current task completes and no new task is accepted.
- All address arithmetic is 64-bit zero-extended. Pointer arithmetic is 16-bit.

Test Plan:
- Slot read: spill_base=0x1000, coal_id=6, out_ready=1, stalls → araddr=0x1300, arlen=7, arsize=4; 8 tasks emitted in order; scratch read at scratch_base+4.
- Counter not full: scratch returns 1 → writes 2; no stack access; lock asserted 2 cycles after last beat, released before IDLE.
- Chunk complete: scratch=3 → writes 0; ptr read 10 → entry 1 written at stack_base+36, then ptr 9 written; err=0.
- Backpressure: out_ready toggled 1,0,0,1 per cycle → rready mirrors out_ready; no duplicated or dropped beats; emission ends after 8 accepted beats.
- Lock contention: stack_lock_in=1 for 5 cycles at GRAB_LOCK → no AXI activity until 1 cycle after it drops. Same-cycle grab by both sides → splitter proceeds.
- Underflow and reset: ptr read 0 → err=1, no writes, lock released. rstn pulsed mid-STREAM → outputs 0 asynchronously; next task processes normally.
